mac_dot_seq: RTL and testbench

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_dot_seq.sv | 132 +++++++++++++
 tb/tb_mac_dot_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and widths for the dot-product sequencer and its MULADD_WRAP environment.
package mac_pkg;

  localparam int OP_W        = 8;
  localparam int ACC_W       = 20;
  localparam int VEC_LEN_MAX = 16;
  localparam int CNT_W       = $clog2(VEC_LEN_MAX);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mac_dot_seq.sv
// Initiator for an accumulate-mode MULADD: streams VEC_LEN operand pairs, returns the dot product.
// Optional feature macro: MAC_DOT_SEQ_PERF_EN adds a saturating perf_cnt of completed results.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int MUL_LAT = 1
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic [ACC_W-1:0] mac_c,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_q
`ifdef MAC_DOT_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_cnt
`endif
);

  mac_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       drain_r;
  logic             xfer_s, last_s, drain_done_s, out_fire_s;
  logic             in_ready_s, out_valid_s, mac_clr_s;

  assign xfer_s       = in_valid && in_ready;
  assign last_s       = (cnt_r == CNT_W'(VEC_LEN - 1));
  // One extra DRAIN cycle covers the mac_a/mac_b register ahead of the MULADD.
  assign drain_done_s = (drain_r == 2'(MUL_LAT));
  assign out_fire_s   = out_valid && out_ready;
  assign mac_c        = {ACC_W{1'b0}};

  // State register
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      CLEAR:   state_nx_s = ACCUM;
      ACCUM:   if (xfer_s && last_s) state_nx_s = DRAIN; else state_nx_s = ACCUM;
      DRAIN:   if (drain_done_s) state_nx_s = OUT; else state_nx_s = DRAIN;
      OUT:     if (out_fire_s) state_nx_s = CLEAR; else state_nx_s = OUT;
      default: state_nx_s = CLEAR;
    endcase
  end

  // Output decode from the next state so the handshake outputs come straight from flops
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    mac_clr_s   = 1'b0;
    case (state_nx_s)
      CLEAR:   mac_clr_s   = 1'b1;
      ACCUM:   in_ready_s  = 1'b1;
      DRAIN:   in_ready_s  = 1'b0;
      OUT:     out_valid_s = 1'b1;
      default: mac_clr_s   = 1'b1;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mac_clr   <= 1'b1;
    end else begin
      in_ready  <= in_ready_s;
      out_valid <= out_valid_s;
      mac_clr   <= mac_clr_s;
    end
  end

  // Operand registers and element counter; idle cycles feed zero into the MULADD
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
      mac_a <= {OP_W{1'b0}};
      mac_b <= {OP_W{1'b0}};
    end else if (xfer_s) begin
      cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      mac_a <= in_a;
      mac_b <= in_b;
    end else begin
      mac_a <= {OP_W{1'b0}};
      mac_b <= {OP_W{1'b0}};
    end
  end

  // Drain timer and result capture
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      drain_r  <= 2'd0;
      out_data <= {ACC_W{1'b0}};
    end else if (state_r == DRAIN) begin
      drain_r <= drain_done_s ? 2'd0 : drain_r + 2'd1;
      if (drain_done_s) out_data <= mac_q;
    end else begin
      drain_r <= 2'd0;
    end
  end

`ifdef MAC_DOT_SEQ_PERF_EN
  // Saturating count of completed result handshakes
  always_ff @(posedge CLK) begin
    if (!rstn) begin
      perf_cnt <= 16'h0000;
    end else if (out_fire_s && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'h0001;
    end else begin
      perf_cnt <= perf_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: six instances (VEC_LEN 4/16/2 x MUL_LAT 1/2), each paired with a behavioural MULADD.
module tb_mac_dot_seq;

  localparam int NI = 6;

  logic        CLK;
  logic        rstn;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [7:0]  in_a      [NI];
  logic [7:0]  in_b      [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [19:0] out_data  [NI];
  logic [7:0]  mac_a     [NI];
  logic [7:0]  mac_b     [NI];
  logic [19:0] mac_c     [NI];
  logic        mac_clr   [NI];
  logic [19:0] mac_q     [NI];
  logic [7:0]  ad        [NI];
  logic [7:0]  bd        [NI];
`ifdef MAC_DOT_SEQ_PERF_EN
  logic [15:0] perf_cnt  [NI];
`endif

  logic [7:0] pa [16];
  logic [7:0] pb [16];
  int total = 0;
  int bad   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_dot_seq #(
      .VEC_LEN((g % 3 == 0) ? 4 : ((g % 3 == 1) ? 16 : 2)),
      .MUL_LAT((g < 3) ? 1 : 2)
    ) u_dut (
      .CLK(CLK), .rstn(rstn),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .mac_a(mac_a[g]), .mac_b(mac_b[g]), .mac_c(mac_c[g]),
      .mac_clr(mac_clr[g]), .mac_q(mac_q[g])
`ifdef MAC_DOT_SEQ_PERF_EN
      , .perf_cnt(perf_cnt[g])
`endif
    );
  end

  function automatic int vl_of(input int k);
    return (k % 3 == 0) ? 4 : ((k % 3 == 1) ? 16 : 2);
  endfunction

  function automatic int ml_of(input int k);
    return (k < 3) ? 1 : 2;
  endfunction

  // Behavioural MULADD: Q <= clr ? 0 : Q + A*B, with A/B delayed MUL_LAT-1 edges
  always @(posedge CLK) begin
    for (int k = 0; k < NI; k++) begin
      ad[k] <= mac_a[k];
      bd[k] <= mac_b[k];
      if (mac_clr[k]) mac_q[k] <= 20'd0;
      else if (ml_of(k) == 1) mac_q[k] <= mac_q[k] + 20'(mac_a[k]) * 20'(mac_b[k]);
      else mac_q[k] <= mac_q[k] + 20'(ad[k]) * 20'(bd[k]);
    end
  end

  // Streams pa/pb[0..n-1] with gap idle cycles after each transfer, then holds out_ready low for bp result cycles
  task automatic run_vec(input int k, input int n, input int gap, input int bp, input string name);
    int i, cyc, gap_left, vcyc;
    logic [19:0] want, held;
    bit rdy_bad, stable_bad, done;
    want = 20'd0; i = 0; cyc = 0; gap_left = 0;
    out_ready[k] = 1'b0;
    @(negedge CLK);
    while (i < n && cyc < 300) begin
      if (gap_left > 0) begin
        in_valid[k] = 1'b0; in_a[k] = 8'($urandom); in_b[k] = 8'($urandom);
        gap_left--;
      end else begin
        in_valid[k] = 1'b1; in_a[k] = pa[i]; in_b[k] = pb[i];
        if (in_ready[k]) begin
          want += 20'(pa[i]) * 20'(pb[i]);
          i++;
          gap_left = gap;
        end
      end
      @(negedge CLK); cyc++;
    end
    total++;
    if (i != n) begin bad++; $display("FAIL %s[%0d] accept: got %0d pairs want %0d", name, k, i, n); end
    // Offer junk pairs while the result drains; none may be accepted
    in_valid[k] = 1'b1; in_a[k] = 8'($urandom); in_b[k] = 8'($urandom);
    vcyc = 0; rdy_bad = 1'b0; stable_bad = 1'b0; done = 1'b0; cyc = 0; held = 20'd0;
    while (!done && cyc < 100) begin
      if (in_ready[k]) rdy_bad = 1'b1;
      if (out_valid[k]) begin
        if (vcyc == 0) held = out_data[k];
        else if (out_data[k] !== held) stable_bad = 1'b1;
        vcyc++;
        out_ready[k] = (vcyc > bp);
        done = out_ready[k];
      end
      @(negedge CLK); cyc++;
    end
    total++;
    if (!done) begin bad++; $display("FAIL %s[%0d] handshake: got timeout want out_valid", name, k); end
    total++;
    if (held !== want) begin bad++; $display("FAIL %s[%0d] result: got %0d want %0d", name, k, held, want); end
    total++;
    if (vcyc != bp + 1) begin bad++; $display("FAIL %s[%0d] valid_cycles: got %0d want %0d", name, k, vcyc, bp + 1); end
    total++;
    if (stable_bad) begin bad++; $display("FAIL %s[%0d] hold: got changing out_data want stable %0d", name, k, held); end
    total++;
    if (rdy_bad) begin bad++; $display("FAIL %s[%0d] ready_drain: got in_ready=1 want 0", name, k); end
    total++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0 || mac_clr[k] !== 1'b1 || mac_c[k] !== 20'd0) begin
      bad++;
      $display("FAIL %s[%0d] clear_cycle: got valid=%b ready=%b clr=%b c=%0d want 0 0 1 0",
               name, k, out_valid[k], in_ready[k], mac_clr[k], mac_c[k]);
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; in_a[k] = 8'd0; in_b[k] = 8'd0; out_ready[k] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    for (int k = 0; k < NI; k++) begin
      total++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0 || out_data[k] !== 20'd0 ||
          mac_a[k] !== 8'd0 || mac_b[k] !== 8'd0 || mac_clr[k] !== 1'b1 || mac_c[k] !== 20'd0) begin
        bad++;
        $display("FAIL reset[%0d]: got valid=%b ready=%b data=%0d a=%0d b=%0d clr=%b want 0 0 0 0 0 1",
                 k, out_valid[k], in_ready[k], out_data[k], mac_a[k], mac_b[k], mac_clr[k]);
      end
    end
    rstn = 1'b1;
    @(negedge CLK);
    total++;
    if (in_ready[0] !== 1'b1 || mac_clr[0] !== 1'b0) begin
      bad++; $display("FAIL reset_release: got ready=%b clr=%b want 1 0", in_ready[0], mac_clr[0]);
    end
  endtask

  task automatic test_back_to_back(input int k);
    for (int i = 0; i < 4; i++) begin pa[i] = 8'(2 * i + 1); pb[i] = 8'(2 * i + 2); end
    run_vec(k, 4, 0, 0, "back_to_back");
  endtask

  task automatic test_gaps_backpressure(input int k);
    for (int i = 0; i < 4; i++) begin pa[i] = 8'(2 * i + 1); pb[i] = 8'(2 * i + 2); end
    run_vec(k, 4, 2, 5, "gaps_bp");
  endtask

  task automatic test_max(input int k);
    for (int i = 0; i < 16; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
    run_vec(k, 16, 0, 0, "max");
  endtask

  task automatic test_two_vectors(input int k);
    pa[0] = 8'd10; pb[0] = 8'd10; pa[1] = 8'd1; pb[1] = 8'd1;
    run_vec(k, 2, 0, 0, "two_vec_a");
    pa[0] = 8'd2; pb[0] = 8'd3; pa[1] = 8'd4; pb[1] = 8'd5;
    run_vec(k, 2, 0, 0, "two_vec_b");
  endtask

  task automatic test_reset_mid(input int k);
    int acc, cyc;
    acc = 0; cyc = 0;
    @(negedge CLK);
    while (acc < 2 && cyc < 100) begin
      in_valid[k] = 1'b1; in_a[k] = 8'd9; in_b[k] = 8'd9;
      if (in_ready[k]) acc++;
      @(negedge CLK); cyc++;
    end
    total++;
    if (acc != 2) begin bad++; $display("FAIL reset_mid[%0d] partial: got %0d want 2", k, acc); end
    rstn = 1'b0; in_valid[k] = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0 || out_data[k] !== 20'd0 || mac_a[k] !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid[%0d] state: got valid=%b ready=%b data=%0d a=%0d want 0 0 0 0",
               k, out_valid[k], in_ready[k], out_data[k], mac_a[k]);
    end
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin pa[i] = 8'd1; pb[i] = 8'd1; end
    run_vec(k, 4, 0, 0, "reset_mid");
`ifdef MAC_DOT_SEQ_PERF_EN
    total++;
    if (perf_cnt[k] !== 16'd1) begin bad++; $display("FAIL perf_cnt[%0d]: got %0d want 1", k, perf_cnt[k]); end
`endif
  endtask

  task automatic test_random(input int k, input int nvec);
    for (int v = 0; v < nvec; v++) begin
      for (int i = 0; i < 16; i++) begin
        pa[i] = 8'($urandom_range(255, 0)); pb[i] = 8'($urandom_range(255, 0));
      end
      run_vec(k, vl_of(k), $urandom_range(2, 0), $urandom_range(3, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    for (int m = 0; m < 2; m++) begin
      test_back_to_back(3 * m);
      test_gaps_backpressure(3 * m);
      test_max(3 * m + 1);
      test_two_vectors(3 * m + 2);
      test_reset_mid(3 * m);
    end
    for (int k = 0; k < NI; k++) test_random(k, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
